mmio_fifo_responder: RTL and testbench

//  Data-bus responder: the target end of the CPU data bus (read/write enable, byte enable,

---
 rtl/mmio_fifo_responder_pkg.sv | 33 +++
 rtl/mmio_fifo_responder_if.sv | 37 +++
 rtl/mmio_fifo_responder_sync_fifo.sv | 70 +++++++
 rtl/mmio_fifo_responder.sv | 124 ++++++++++++
 tb/tb_mmio_fifo_responder.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_fifo_responder_pkg.sv
// Shared definitions for the MMIO byte-stream responder: register selectors,
// STAT bit positions, CTRL bits and the size of the decoded address window.
package mmio_fifo_responder_pkg;

  // Register selected by address bits [3:2] inside the window.
  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_sel_e;

  // Bytes decoded by the block, starting at BASE_ADDR.
  localparam logic [31:0] WINDOW_BYTES = 32'd16;

  // DATA read: bit 31 flags that the returned RX byte is real.
  localparam int DATA_VALID_BIT = 31;

  // STAT layout.
  localparam int STAT_RX_EMPTY   = 0;
  localparam int STAT_RX_FULL    = 1;
  localparam int STAT_TX_EMPTY   = 2;
  localparam int STAT_TX_FULL    = 3;
  localparam int STAT_RX_OVF     = 4;
  localparam int STAT_TX_OVF     = 5;
  localparam int STAT_RX_CNT_LSB = 8;
  localparam int STAT_TX_CNT_LSB = 16;

  // CTRL write bits (byte lane 0).
  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/mmio_fifo_responder_if.sv
// Bus and device-stream signals of the MMIO FIFO responder. The responder
// uses the slave view; whoever drives the bus and the devices uses master.
interface mmio_fifo_responder_if #(
  parameter int DATA_W = 8
);
  logic              iReadEnable;
  logic              iWriteEnable;
  logic [3:0]        iByteEnable;
  logic [31:0]       iAddress;
  logic [31:0]       iWriteData;
  logic [31:0]       oReadData;
  logic              oHit;
  logic [DATA_W-1:0] oTxData;
  logic              oTxValid;
  logic              iTxReady;
  logic [DATA_W-1:0] iRxData;
  logic              iRxValid;
  logic              oRxReady;

  modport slave (
    input  iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    output oReadData, oHit,
    output oTxData, oTxValid,
    input  iTxReady,
    input  iRxData, iRxValid,
    output oRxReady
  );

  modport master (
    output iReadEnable, iWriteEnable, iByteEnable, iAddress, iWriteData,
    input  oReadData, oHit,
    input  oTxData, oTxValid,
    output iTxReady,
    output iRxData, iRxValid,
    input  oRxReady
  );
endinterface

// File: rtl/mmio_fifo_responder_sync_fifo.sv
// Single-clock FIFO with a combinationally readable head. Push is ignored
// while full, pop is ignored while empty, and flush overrides both.
module mmio_fifo_responder_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok, mem_we;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign mem_we  = push_ok & ~flush;
  // An empty FIFO presents zero rather than a stale entry.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer/count registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_fifo_responder.sv
// Memory-mapped byte-stream port: a TX FIFO filled by CPU writes to DATA and
// drained by a device, and an RX FIFO filled by a device and popped by CPU
// reads of DATA. Reads are combinational; pops and pushes commit at the edge.
module mmio_fifo_responder
  import mmio_fifo_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  mmio_fifo_responder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]       offset;
  logic              hit;
  reg_sel_e          sel;
  logic              tx_push, tx_pop, rx_pop, ctrl_wr, ovf_clr, flush;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [31:0]       rdata;
  logic              unused_bits;

  // Unsigned distance from the base: anything below the base wraps to a huge
  // value, so one compare covers both ends of the window.
  assign offset = bus.iAddress - BASE_ADDR;
  assign hit    = (offset < WINDOW_BYTES);
  assign sel    = reg_sel_e'(offset[3:2]);

  assign tx_push = bus.iWriteEnable & hit & (sel == REG_DATA) & bus.iByteEnable[0];
  assign ctrl_wr = bus.iWriteEnable & hit & (sel == REG_CTRL) & bus.iByteEnable[0];
  assign ovf_clr = ctrl_wr & bus.iWriteData[CTRL_CLR_OVF];
  assign flush   = ctrl_wr & bus.iWriteData[CTRL_FLUSH];
  assign rx_pop  = bus.iReadEnable & hit & (sel == REG_DATA);
  assign tx_pop  = ~tx_empty & bus.iTxReady;

  // Only the low DATA_W write bits and byte lane 0 carry meaning.
  assign unused_bits = ^{bus.iWriteData[31:DATA_W], bus.iByteEnable[3:1]};

  mmio_fifo_responder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk       (iCLK),
    .srst      (iRST),
    .push      (tx_push),
    .push_data (bus.iWriteData[DATA_W-1:0]),
    .pop       (tx_pop),
    .flush     (flush),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (tx_head)
  );

  mmio_fifo_responder_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk       (iCLK),
    .srst      (iRST),
    .push      (bus.iRxValid),
    .push_data (bus.iRxData),
    .pop       (rx_pop),
    .flush     (flush),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (rx_head)
  );

  assign bus.oTxData  = tx_head;
  assign bus.oTxValid = ~tx_empty;
  assign bus.oRxReady = ~rx_full;
  assign bus.oHit     = hit;

  // Sticky overflow flags: a new event in the clearing cycle wins over the clear.
  always_comb begin
    tx_ovf_d = (tx_ovf_q & ~ovf_clr) | (tx_push & tx_full);
    rx_ovf_d = (rx_ovf_q & ~ovf_clr) | (bus.iRxValid & rx_full);
  end

  // Overflow flag registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

  // Zero-latency read mux; misses and write-only registers read as zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_DATA: begin
          rdata[DATA_W-1:0]     = rx_head;
          rdata[DATA_VALID_BIT] = ~rx_empty;
        end
        REG_STAT: begin
          rdata[STAT_RX_EMPTY]           = rx_empty;
          rdata[STAT_RX_FULL]            = rx_full;
          rdata[STAT_TX_EMPTY]           = tx_empty;
          rdata[STAT_TX_FULL]            = tx_full;
          rdata[STAT_RX_OVF]             = rx_ovf_q;
          rdata[STAT_TX_OVF]             = tx_ovf_q;
          rdata[STAT_RX_CNT_LSB +: CW]   = rx_count;
          rdata[STAT_TX_CNT_LSB +: CW]   = tx_count;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign bus.oReadData = rdata;

endmodule

// File: tb/tb_mmio_fifo_responder.sv
// Directed bench for mmio_fifo_responder: a queue-based model of the register
// map is checked against the DUT every cycle, and hand-computed literals pin
// the model at the interesting points of the sequence.
module tb_mmio_fifo_responder;
  localparam logic [31:0] BASE  = 32'hFF20_0100;
  localparam int          DW    = 8;
  localparam int          DEPTH = 16;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmio_fifo_responder_if #(.DATA_W(DW)) bus ();

  mmio_fifo_responder #(
    .BASE_ADDR (BASE),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: FIFO contents as queues plus the two sticky flags.
  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  bit            m_tx_ovf = 0;
  bit            m_rx_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd15);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (in_window(a)) begin
      case ((a - BASE) / 4)
        0: if (m_rx.size() > 0) r = 32'h8000_0000 + 32'(m_rx[0]);
        1: begin
          if (m_rx.size() == 0)     r = r + 32'h01;
          if (m_rx.size() == DEPTH) r = r + 32'h02;
          if (m_tx.size() == 0)     r = r + 32'h04;
          if (m_tx.size() == DEPTH) r = r + 32'h08;
          if (m_rx_ovf)             r = r + 32'h10;
          if (m_tx_ovf)             r = r + 32'h20;
          r = r + 32'(m_rx.size()) * 256 + 32'(m_tx.size()) * 65536;
        end
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // Compare outputs against the model on each falling edge, then advance the
  // model by what the next rising edge will do with the inputs now applied.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("hit", 32'(bus.oHit), 32'(in_window(bus.iAddress)));
        check("rdata", bus.oReadData, model_read(bus.iAddress));
        check("tx_valid", 32'(bus.oTxValid), 32'(m_tx.size() > 0));
        check("tx_data", 32'(bus.oTxData), (m_tx.size() > 0) ? 32'(m_tx[0]) : 32'h0);
        check("rx_ready", 32'(bus.oRxReady), 32'(m_rx.size() < DEPTH));
      end
      if (rst) begin
        m_tx.delete();
        m_rx.delete();
        m_tx_ovf = 0;
        m_rx_ovf = 0;
      end else begin
        bit          hitv, wr_data, wr_ctrl, rd_data, clr, fl, tx_full0, rx_full0, tx_ev, rx_ev;
        logic [31:0] reg_idx;
        hitv    = in_window(bus.iAddress);
        reg_idx = (bus.iAddress - BASE) / 4;
        wr_data = bus.iWriteEnable && hitv && reg_idx == 0 && bus.iByteEnable[0];
        wr_ctrl = bus.iWriteEnable && hitv && reg_idx == 2 && bus.iByteEnable[0];
        rd_data = bus.iReadEnable && hitv && reg_idx == 0;
        clr     = wr_ctrl && bus.iWriteData[0];
        fl      = wr_ctrl && bus.iWriteData[1];
        tx_full0 = (m_tx.size() == DEPTH);
        rx_full0 = (m_rx.size() == DEPTH);
        tx_ev    = wr_data && tx_full0;
        rx_ev    = bus.iRxValid && rx_full0;
        if (fl) begin
          m_tx.delete();
          m_rx.delete();
        end else begin
          if (m_tx.size() > 0 && bus.iTxReady) void'(m_tx.pop_front());
          if (wr_data && !tx_full0) m_tx.push_back(bus.iWriteData[DW-1:0]);
          if (rd_data && m_rx.size() > 0) void'(m_rx.pop_front());
          if (bus.iRxValid && !rx_full0) m_rx.push_back(bus.iRxData);
        end
        m_tx_ovf = (m_tx_ovf && !clr) || tx_ev;
        m_rx_ovf = (m_rx_ovf && !clr) || rx_ev;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.iReadEnable  = 1'b0;
    bus.iWriteEnable = 1'b0;
    bus.iByteEnable  = 4'h0;
    bus.iAddress     = 32'h0;
    bus.iWriteData   = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.iWriteEnable = 1'b1;
    bus.iAddress     = a;
    bus.iWriteData   = d;
    bus.iByteEnable  = be;
    $display("WR  addr=%h data=%h be=%b", a, d, be);
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    bus.iReadEnable = 1'b1;
    bus.iAddress    = a;
    #2;
    $display("RD  addr=%h data=%h", a, bus.oReadData);
    check(name, bus.oReadData, exp);
    step();
    bus_idle();
  endtask

  task automatic probe_hit(input logic [31:0] a, input logic exp);
    bus.iAddress = a;
    #2;
    $display("HIT addr=%h hit=%b", a, bus.oHit);
    check("hit probe", 32'(bus.oHit), 32'(exp));
    step();
    bus_idle();
  endtask

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_idle();
    bus.iTxReady = 1'b0;
    bus.iRxValid = 1'b0;
    bus.iRxData  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    #1;
    check("reset tx_valid", 32'(bus.oTxValid), 32'h0);
    check("reset rx_ready", 32'(bus.oRxReady), 32'h1);
    check("reset tx_data", 32'(bus.oTxData), 32'h0);
    rd(A_STAT, "reset STAT", 32'h0000_0005);

    // Two TX bytes held, then drained back to back.
    wr(A_DATA, 32'h41, 4'h1);
    wr(A_DATA, 32'h42, 4'h1);
    rd(A_STAT, "STAT tx_count=2", 32'h0002_0001);
    #1;
    check("tx head 0x41", 32'(bus.oTxData), 32'h41);
    bus.iTxReady = 1'b1;
    #1;
    check("drain first", 32'(bus.oTxData), 32'h41);
    step();
    check("drain second", 32'(bus.oTxData), 32'h42);
    step();
    check("drained valid", 32'(bus.oTxValid), 32'h0);
    bus.iTxReady = 1'b0;

    // 17 writes into a 16-deep TX: last one dropped and flagged.
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'(i + 1), 4'h1);
    rd(A_STAT, "STAT tx full+ovf", 32'h0010_0029);
    check("tx head after fill", 32'(bus.oTxData), 32'h01);
    wr(A_CTRL, 32'h1, 4'h1);
    rd(A_STAT, "STAT ovf cleared", 32'h0010_0009);
    wr(A_CTRL, 32'h2, 4'h1);
    rd(A_STAT, "STAT after flush", 32'h0000_0005);

    // One RX byte, then a pop from empty.
    bus.iRxValid = 1'b1;
    bus.iRxData  = 8'h5A;
    step();
    bus.iRxValid = 1'b0;
    rd(A_DATA, "DATA rx 0x5A", 32'h8000_005A);
    rd(A_DATA, "DATA rx empty", 32'h0000_0000);

    // Fill RX, then offer while full during a CPU pop. Ready is low at that
    // edge, so the byte is refused and flagged while the pop still happens.
    for (int i = 0; i < 16; i++) begin
      bus.iRxData  = 8'(8'h10 + i);
      bus.iRxValid = 1'b1;
      step();
    end
    bus.iRxValid = 1'b0;
    #1;
    check("rx_ready when full", 32'(bus.oRxReady), 32'h0);
    bus.iRxValid = 1'b1;
    bus.iRxData  = 8'hEE;
    rd(A_DATA, "DATA pop while full", 32'h8000_0010);
    bus.iRxValid = 1'b0;
    rd(A_STAT, "STAT rx ovf", 32'h0000_0F14);
    rd(A_DATA, "DATA next rx", 32'h8000_0011);
    for (int i = 0; i < 2; i++) begin
      bus.iRxData  = 8'(8'h20 + i);
      bus.iRxValid = 1'b1;
      step();
    end
    // Clear and a new overflow in the same cycle: flag stays set.
    bus.iRxValid = 1'b1;
    bus.iRxData  = 8'hEF;
    wr(A_CTRL, 32'h1, 4'h1);
    bus.iRxValid = 1'b0;
    rd(A_STAT, "STAT clear vs ovf", 32'h0000_1016);
    wr(A_CTRL, 32'h3, 4'h1);
    rd(A_STAT, "STAT clean", 32'h0000_0005);

    // Flush beats a same-cycle device pop and device push.
    wr(A_DATA, 32'hA1, 4'h1);
    wr(A_DATA, 32'hA2, 4'h1);
    wr(A_DATA, 32'hA3, 4'h1);
    rd(A_STAT, "STAT tx 3", 32'h0003_0001);
    bus.iTxReady = 1'b1;
    bus.iRxValid = 1'b1;
    bus.iRxData  = 8'h77;
    wr(A_CTRL, 32'h2, 4'h1);
    bus.iTxReady = 1'b0;
    bus.iRxValid = 1'b0;
    rd(A_STAT, "STAT flush priority", 32'h0000_0005);

    // Window edges, ignored low address bits, and misses with no effect.
    probe_hit(BASE, 1'b1);
    probe_hit(BASE + 32'hC, 1'b1);
    probe_hit(BASE + 32'h10, 1'b0);
    probe_hit(BASE - 32'h4, 1'b0);
    wr(BASE + 32'h10, 32'h99, 4'hF);
    wr(BASE - 32'h8, 32'h3, 4'h1);
    rd(BASE + 32'h10, "read outside", 32'h0000_0000);
    rd(BASE + 32'h6, "STAT low bits ignored", 32'h0000_0005);
    rd(A_CTRL, "CTRL reads 0", 32'h0000_0000);
    rd(BASE + 32'hC, "0xC reads 0", 32'h0000_0000);

    // DATA write without byte lane 0 pushes nothing.
    wr(A_DATA, 32'h55, 4'b1110);
    rd(A_STAT, "STAT be0 clear", 32'h0000_0005);

    // Reset mid-transfer discards both FIFOs.
    wr(A_DATA, 32'hC1, 4'h1);
    bus.iRxValid = 1'b1;
    bus.iRxData  = 8'hC2;
    step();
    bus.iRxValid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("post-reset tx_valid", 32'(bus.oTxValid), 32'h0);
    rd(A_STAT, "STAT after reset", 32'h0000_0005);

    // CPU push and device pop in the same cycle keep the count.
    wr(A_DATA, 32'hB1, 4'h1);
    wr(A_DATA, 32'hB2, 4'h1);
    bus.iTxReady = 1'b1;
    wr(A_DATA, 32'hB3, 4'h1);
    bus.iTxReady = 1'b0;
    rd(A_STAT, "STAT push+pop", 32'h0002_0001);
    #1;
    check("tx head after push+pop", 32'(bus.oTxData), 32'hB2);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
